// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack fetch from instruction memory, next-PC select.
// Optional fetch timeout with sticky fetch_err and HALT state when FETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  OpCode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        ex_done,
    input  logic        jump,
    input  logic        Branch,
    input  logic        br_taken,
    output logic        fetch_err
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {StBoot, StReq, StHold, StHalt} state_e;
    localparam logic [4:0] TimeoutLast = 5'(TIMEOUT_CYC - 1);
`else
    typedef enum logic [1:0] {StBoot, StReq, StHold} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
    logic [4:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        pc4     = pc_q + 32'd4;
        br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        next_pc = pc4;
        if (jump) begin
            next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
        end else if (Branch && br_taken) begin
            next_pc = pc4 + br_off;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req_d   = req_q;
`ifdef FETCH_TIMEOUT_EN
        // Counter is held at zero outside REQ, so it is clear on every entry to REQ.
        cnt_d   = '0;
        err_d   = err_q;
`endif
        unique case (state_q)
            StBoot: begin
                state_d = StReq;
                req_d   = 1'b1;
            end
            StReq: begin
                if (req_q && imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = StHold;
`ifdef FETCH_TIMEOUT_EN
                end else if (cnt_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = StHalt;
                end else begin
                    cnt_d = cnt_q + 5'd1;
`endif
                end
            end
            StHold: begin
                if (ex_done) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = StReq;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            StHalt: begin
                req_d = 1'b0;
            end
`endif
            default: begin
                state_d = StBoot;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign fetch_err      = 1'b0;
`endif

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign OpCode      = instr_q[31:26];
    assign funct       = instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table of fetch/next-PC cases plus reset and
// timeout sequences (timeout expectations depend on FETCH_TIMEOUT_EN).
module tb_instr_fetch_unit;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [5:0]  OpCode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic        ex_done = 1'b0;
    logic        jump = 1'b0;
    logic        Branch = 1'b0;
    logic        br_taken = 1'b0;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .RESET_PC    (32'h0000_3000),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .OpCode      (OpCode),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .ex_done     (ex_done),
        .jump        (jump),
        .Branch      (Branch),
        .br_taken    (br_taken),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          delay;
        logic        j;
        logic        b;
        logic        t;
        logic [31:0] exp_addr;
        logic [5:0]  exp_op;
        logic [5:0]  exp_fn;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h3408_0005, 0, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 6'h0D, 6'h05, 32'h0000_3004};
        vecs[1] = '{32'h0109_4020, 5, 1'b0, 1'b0, 1'b0, 32'h0000_3004, 6'h00, 6'h20, 32'h0000_3008};
        vecs[2] = '{32'h1000_FFFF, 2, 1'b0, 1'b1, 1'b1, 32'h0000_3008, 6'h04, 6'h3F, 32'h0000_3008};
        vecs[3] = '{32'h1000_FFFF, 0, 1'b0, 1'b1, 1'b0, 32'h0000_3008, 6'h04, 6'h3F, 32'h0000_300C};
        vecs[4] = '{32'h8C0A_0004, 1, 1'b0, 1'b0, 1'b1, 32'h0000_300C, 6'h23, 6'h04, 32'h0000_3010};
        vecs[5] = '{32'h0800_0C10, 0, 1'b1, 1'b1, 1'b1, 32'h0000_3010, 6'h02, 6'h10, 32'h0000_3040};
        vecs[6] = '{32'h1000_F3EE, 0, 1'b0, 1'b1, 1'b1, 32'h0000_3040, 6'h04, 6'h2E, 32'hFFFF_FFFC};
        vecs[7] = '{32'h3C01_1234, 1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 6'h0F, 6'h34, 32'h0000_0000};
        vecs[8] = '{32'h1000_0010, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 6'h04, 6'h10, 32'h0000_0044};
        vecs[9] = '{32'h0BFF_FFFF, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 6'h02, 6'h3F, 32'h0FFF_FFFC};

        repeat (3) step();
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);

        // Ack coincident with reset release lands in BOOT and must be dropped.
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("boot_ack_valid", 32'(instr_valid), 32'd0);
        chk("boot_ack_instr", instr, 32'd0);

        for (int v = 0; v < 10; v++) begin
            chk($sformatf("v%0d_req", v), 32'(imem_req), 32'd1);
            chk($sformatf("v%0d_addr", v), imem_addr, vecs[v].exp_addr);
            for (int d = 0; d < vecs[v].delay; d++) begin
                ex_done = (d == 0);
                jump    = 1'b1;
                step();
                ex_done = 1'b0;
                jump    = 1'b0;
                chk($sformatf("v%0d_wait_addr", v), imem_addr, vecs[v].exp_addr);
                chk($sformatf("v%0d_wait_pc", v), pc, vecs[v].exp_addr);
                chk($sformatf("v%0d_wait_valid", v), 32'(instr_valid), 32'd0);
            end
            imem_ack   = 1'b1;
            imem_rdata = vecs[v].rdata;
            step();
            imem_ack = 1'b0;
            chk($sformatf("v%0d_valid", v), 32'(instr_valid), 32'd1);
            chk($sformatf("v%0d_instr", v), instr, vecs[v].rdata);
            chk($sformatf("v%0d_op", v), 32'(OpCode), 32'(vecs[v].exp_op));
            chk($sformatf("v%0d_fn", v), 32'(funct), 32'(vecs[v].exp_fn));
            chk($sformatf("v%0d_hold_req", v), 32'(imem_req), 32'd0);

            // Stray ack in HOLD must not overwrite the instruction.
            imem_ack   = 1'b1;
            imem_rdata = 32'h1234_5678;
            step();
            imem_ack = 1'b0;
            chk($sformatf("v%0d_hold_instr", v), instr, vecs[v].rdata);

            ex_done  = 1'b1;
            jump     = vecs[v].j;
            Branch   = vecs[v].b;
            br_taken = vecs[v].t;
            step();
            ex_done  = 1'b0;
            jump     = 1'b0;
            Branch   = 1'b0;
            br_taken = 1'b0;
            chk($sformatf("v%0d_next_pc", v), pc, vecs[v].exp_next);
            chk($sformatf("v%0d_next_valid", v), 32'(instr_valid), 32'd0);
        end

        // Reset mid-REQ aborts the request asynchronously.
        step();
        chk("midreq_req", 32'(imem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midreq_rst_pc", pc, 32'h0000_3000);
        chk("midreq_rst_req", 32'(imem_req), 32'd0);
        step();
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        step();
        imem_ack = 1'b0;
        chk("late_ack_valid", 32'(instr_valid), 32'd0);
        chk("late_ack_req", 32'(imem_req), 32'd1);
        chk("late_ack_pc", pc, 32'h0000_3000);

        for (int i = 0; i < int'(TO) - 1; i++) begin
            step();
            chk("to_pre_err", 32'(fetch_err), 32'd0);
            chk("to_pre_req", 32'(imem_req), 32'd1);
        end
        step();
`ifdef FETCH_TIMEOUT_EN
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_req", 32'(imem_req), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3408_0005;
        ex_done    = 1'b1;
        repeat (3) step();
        imem_ack = 1'b0;
        ex_done  = 1'b0;
        chk("halt_err", 32'(fetch_err), 32'd1);
        chk("halt_req", 32'(imem_req), 32'd0);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_pc", pc, 32'h0000_3000);
        rst = 1'b0;
        #1;
        chk("halt_rst_err", 32'(fetch_err), 32'd0);
`else
        chk("noto_err", 32'(fetch_err), 32'd0);
        chk("noto_req", 32'(imem_req), 32'd1);
        chk("noto_pc", imem_addr, 32'h0000_3000);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3408_0005;
        step();
        imem_ack = 1'b0;
        chk("noto_late_valid", 32'(instr_valid), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
